booth_pp_accumulator: RTL

BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

---
 rtl/booth_pp_accumulator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/booth_pp_accumulator.sv
// Sequential signed multiplier: one radix-4 Booth digit is accumulated per cycle,
// then the product is published on p with a single-cycle done pulse.
module booth_pp_accumulator #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   p
);

  localparam int DIGITS = W / 2;
  localparam int CW     = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           digits_done;

  logic [W:0]     b_ext;
  logic [2:0]     triplet;
  logic           two;
  logic           neg;
  logic           zero;
  logic [W+1:0]   a_ext;
  logic [W:0]     pp;
  logic [2*W-1:0] pp_ext;
  logic [2*W-1:0] pp_shift;

  // The counter runs one step past the last digit so p is loaded from the settled accumulator.
  assign digits_done = (cnt == CW'(DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (digits_done) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // b[-1] is the appended zero below the LSB of the multiplier.
  assign b_ext = {b_reg, 1'b0};

  always_comb begin
    triplet = 3'b000;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt == CW'(i)) begin
        triplet = b_ext[2*i +: 3];
      end
    end
  end

  assign two  = (triplet == 3'b100) | (triplet == 3'b011);
  assign neg  = triplet[2] & ~(triplet[1] & triplet[0]);
  assign zero = (triplet == 3'b000) | (triplet == 3'b111);

  // a_ext[j+1] is a[j]; bit 0 supplies a[-1]=0 and the top bit a[W]=a[W-1].
  assign a_ext = {a_reg[W-1], a_reg, 1'b0};

  assign pp = ((two ? a_ext[W:0] : a_ext[W+1:1]) ^ {(W+1){neg}}) & {(W+1){~zero}};

  // Completing the two's complement negation here keeps the accumulator a plain adder.
  assign pp_ext   = {{(W-1){pp[W]}}, pp} + {{(2*W-1){1'b0}}, neg & ~zero};
  assign pp_shift = pp_ext << {cnt, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (digits_done) begin
            p <= acc;
          end else begin
            acc <= acc + pp_shift;
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
